// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator: sums FRAME_LEN signed samples per frame with sign-based overflow tracking.
// Define SIGNED_SAT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module signed_sat_accumulator #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_ovf_cnt
);
    typedef enum logic {ACCUM, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
    state_t state, state_nxt;
    logic [WIDTH-1:0] acc, raw, acc_nxt;
    logic [CNT_W-1:0] cnt, ovf_cnt, ovf_cnt_nxt;
    logic ovf, ovf_step, accept, last;
    always_comb begin
        in_ready    = state == ACCUM;
        out_valid   = state == DONE;
        accept      = in_valid && in_ready;
        last        = cnt == LAST;
        raw         = acc + in_data;
        ovf_step    = (acc[WIDTH-1] == in_data[WIDTH-1]) && (raw[WIDTH-1] != acc[WIDTH-1]);
        ovf_cnt_nxt = (ovf_step && ovf_cnt != '1) ? ovf_cnt + 1'b1 : ovf_cnt;
        state_nxt   = (state == ACCUM) ? ((in_valid && last) ? DONE : ACCUM)
                                       : (out_ready ? ACCUM : DONE);
    end
`ifdef SIGNED_SAT_ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    // Overflow only occurs when both operands share acc's sign, so acc[MSB] picks the clamp direction.
    assign acc_nxt = ovf_step ? (acc[WIDTH-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign acc_nxt = raw;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            ovf_cnt     <= '0;
            out_sum     <= '0;
            out_ovf     <= 1'b0;
            out_ovf_cnt <= '0;
        end else if (accept) begin
            acc     <= acc_nxt;
            cnt     <= cnt + 1'b1;
            ovf     <= ovf | ovf_step;
            ovf_cnt <= ovf_cnt_nxt;
            if (last) begin
                out_sum     <= acc_nxt;
                out_ovf     <= ovf | ovf_step;
                out_ovf_cnt <= ovf_cnt_nxt;
            end
        end else if (out_valid && out_ready) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end
    end
endmodule

// File: doc/signed_sat_accumulator.md
# signed_sat_accumulator

Frame accumulator placed directly downstream of the signed 4-bit add-with-overflow stage. It consumes a stream of two's-complement samples over a valid/ready handshake and sums FRAME_LEN samples per frame. Each partial sum uses the same sign-based overflow rule as the adder stage. The block then presents the frame total, a frame overflow flag and an overflow event count to the next consumer, with backpressure.

## Interface
- WIDTH, 4: sample and sum width in bits, two's complement; WIDTH ≥ 2
- FRAME_LEN, 4: number of accepted samples per frame; FRAME_LEN ≥ 1
- CNT_W, $clog2(FRAME_LEN+1): width of the frame sample counter and the overflow counter (derived; not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  WIDTH  signed sample
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes the result
- out_sum  output  WIDTH  signed frame total
- out_ovf  output  1  at least one overflow occurred in the frame
- out_ovf_cnt  output  CNT_W  number of overflowing additions in the frame

## Operation
- Two-state FSM:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (async assert, sync-safe deassert) sets:
  - state=ACCUM
  - acc=0, sample count=0, ovf flag=0, ovf count=0
  - out_valid=0, out_sum=0, out_ovf=0, out_ovf_cnt=0
  - in_ready=1 once rst_n is high.
- A sample is accepted when in_valid && in_ready at the rising edge. On acceptance:
  - raw = acc + in_data, computed modulo 2^WIDTH.
  - ovf_step = (acc[MSB]==in_data[MSB]) && (raw[MSB]!=acc[MSB]).
  - acc takes the result selected by the Configuration section.
  - If ovf_step: ovf flag is set (sticky for the frame) and ovf count increments, saturating at 2^CNT_W−1.
  - Sample count increments.
- On the FRAME_LEN-th acceptance, state moves to DONE. out_sum, out_ovf and out_ovf_cnt are registered copies including that last sample.
- In DONE, all outputs are held stable until out_valid && out_ready. At that edge:
  - state returns to ACCUM
  - acc, sample count, ovf flag and ovf count clear to 0
  - out_valid drops.
- in_valid while in DONE is ignored; the sample is not consumed because in_ready=0.
- in_data is sampled only on acceptance. It may be X when in_valid=0.
- Reset mid-frame or in DONE discards all partial state and any pending result. No result is emitted.

## Timing
- Accumulation is single-cycle per sample; one sample per clock is sustained in ACCUM.
- Latency: out_valid rises the cycle after the edge that accepts the last sample.
- in_ready is a pure function of state (no combinational path from in_valid or out_ready).
- out_valid is a pure function of state.
- Frame throughput with in_valid=1 and out_ready=1 continuously: FRAME_LEN+1 cycles per frame (one DONE cycle).
- Backpressure: out_ready low in DONE stalls indefinitely. All outputs stay bit-stable.
- FRAME_LEN=1: every accepted sample yields a frame. The result is the single sample; ovf is always 0.

## Configuration
- SIGNED_SAT_ACC_SATURATE_EN
  - Defined: on ovf_step, acc clamps toward the overflow direction:
    - positive overflow (both operands non-negative) → 2^(WIDTH−1)−1, i.e. 7 for WIDTH=4
    - negative overflow → −2^(WIDTH−1), i.e. −8
    - otherwise acc=raw.
  - Undefined: acc=raw always (modulo wrap).
  - ovf_step detection, flag and count behave identically in both builds.

## Test plan
All cases use WIDTH=4, FRAME_LEN=4.

- Reset, then samples 1, 2, −1, −2 back-to-back, out_ready=1:
  - out_valid for one cycle, 1 cycle after the 4th acceptance
  - out_sum=0, out_ovf=0, out_ovf_cnt=0.
- Samples 4, 7, −1, 1:
  - saturate build: out_sum=7, out_ovf=1, out_ovf_cnt=1
  - wrap build: out_sum=−5 (4'hB), out_ovf=1, out_ovf_cnt=1.
- Samples −4, −7, −8, −8, saturate build: out_sum=−8, out_ovf=1, out_ovf_cnt=3.
- Frame complete with out_ready=0 for 3 cycles, in_valid=1 throughout:
  - in_ready=0 and outputs stable for all 3 cycles
  - the result is consumed on the 4th cycle
  - the next frame starts from acc=0 and the stalled in_data is accepted only after return to ACCUM.
- Assert rst_n=0 after 2 accepted samples (3, 3):
  - all outputs go to 0 immediately
  - after release, samples 1, 1, 1, 1 give out_sum=4, out_ovf=0.
- Continuous traffic for 3 frames of samples 1, 1, 1, 1 with out_ready=1: out_valid pulses every 5 cycles, each with out_sum=4.
